multdiv_check_sequencer: RTL
============================

MULTDIV_CHECK_SEQUENCER -- requirements
Module: multdiv_check_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL be the maximum number of WAIT cycles allowed before md_resultRDY is declared missing.
REQ-002 Parameter ERR_CNT_W, default 8, SHALL be the width of err_count.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ctrl_MULT / ctrl_DIV  in  1 each  single-cycle request strobes; exactly one high selects the operation.
REQ-006 data_operandA  in  32  dividend or multiplicand; data_operandB  in  16  divisor or multiplier.
REQ-007 md_start  out  1  one-cycle start pulse to multi-cycle multdiv unit; md_MULT, md_DIV  out  1 each  registered op select; md_operandA  out  32, md_operandB  out  16  registered operands.
REQ-008 md_result  in  32, md_remainder  in  32, md_resultRDY  in  1  multdiv unit outputs.
REQ-009 chk_inA  out  32, chk_inB  out  16, chk_result  out  32, chk_remainder  out  32, chk_MULT  out  1, chk_DIV  out  1  drive the residue (mod-31) checker; chk_outError  in  1  checker verdict.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 data_result  out  32, data_remainder  out  32, data_resultRDY  out  1 (one-cycle pulse), data_exception  out  1 (valid with data_resultRDY).
REQ-012 timeout  out  1  valid with data_resultRDY; fault_sticky  out  1; err_count  out  ERR_CNT_W; clear_fault  in  1  synchronous clear.

Function
REQ-013 FSM states SHALL be IDLE, START, WAIT, CHECK, DONE.
REQ-014 IDLE: request accepted iff ctrl_MULT XOR ctrl_DIV; operands and op latched that edge; next START. Both or neither high -> stay IDLE, no latch.
REQ-015 Requests in any non-IDLE state SHALL be ignored (no queueing).
REQ-016 START: md_start=1 for exactly one cycle; timeout counter cleared; next WAIT.
REQ-017 WAIT: counter increments each cycle; md_resultRDY=1 -> latch md_result, md_remainder; next CHECK.
REQ-018 WAIT: counter reaching TIMEOUT_CYCLES-1 with md_resultRDY=0 -> latched result/remainder forced to 0, timeout flag set, next DONE (CHECK skipped); md_resultRDY on that same cycle takes priority over timeout.
REQ-019 md_resultRDY outside WAIT SHALL be ignored.
REQ-020 CHECK (one cycle): chk_* driven from latched registers; chk_MULT/chk_DIV = latched op; chk_outError sampled at end of cycle; next DONE.
REQ-021 chk_MULT and chk_DIV SHALL be 0 outside CHECK; chk_* data outputs hold latched values at all times.
REQ-022 DONE: data_resultRDY=1 one cycle; data_result/data_remainder = latched values (held until next accept); data_exception = sampled chk_outError OR timeout; next IDLE.
REQ-023 Latency: accept edge T -> data_resultRDY in cycle T+3+N, N = WAIT cycles including RDY cycle (minimum N=1 -> T+4).
REQ-024 In DONE, exception sets fault_sticky and increments err_count; err_count saturates at all-ones.
REQ-025 clear_fault=1 clears fault_sticky and err_count; simultaneous with DONE exception, the set/increment wins (fault_sticky=1, err_count=1).
REQ-026 For DIV, md_remainder passes unmodified to chk_remainder; checker performs negation.

Reset
REQ-027 reset asserted SHALL immediately force IDLE and zero every output and internal register, including fault_sticky and err_count, regardless of state.
REQ-028 Reset mid-operation SHALL abandon the operation with no data_resultRDY; late md_resultRDY after release SHALL be ignored (IDLE).

Verification
REQ-029 MULT A=7,B=6; md_resultRDY at 3rd WAIT cycle with result 42 -> data_resultRDY at T+6, data_result=42, data_exception=0, err_count=0.
REQ-030 DIV A=100,B=7; result 14, remainder 2 -> data_result=14, data_remainder=2, exception=0; chk_DIV=1 only in CHECK cycle.
REQ-031 MULT A=7,B=6, result 43, chk_outError=1 -> data_exception=1, fault_sticky=1, err_count=1; clear_fault next cycle -> both 0.
REQ-032 MULT with md_resultRDY never asserted, TIMEOUT_CYCLES=64 -> data_resultRDY at T+66, timeout=1, data_exception=1, data_result=0.
REQ-033 reset pulse during WAIT, md_resultRDY one cycle later -> busy=0, no data_resultRDY, all outputs 0; new request afterwards completes normally.
REQ-034 ctrl_MULT=ctrl_DIV=1 in IDLE -> no md_start; ctrl_MULT during WAIT -> ignored, single data_resultRDY for original op.

Source files
------------

// File: rtl/multdiv_check_sequencer.sv
// Sequences one multdiv operation at a time: start pulse, bounded wait for the
// result, a one-cycle residue-check pass, then a result strobe with fault tracking.
module multdiv_check_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ctrl_MULT,
    input  logic                 ctrl_DIV,
    input  logic [31:0]          data_operandA,
    input  logic [15:0]          data_operandB,
    output logic                 md_start,
    output logic                 md_MULT,
    output logic                 md_DIV,
    output logic [31:0]          md_operandA,
    output logic [15:0]          md_operandB,
    input  logic [31:0]          md_result,
    input  logic [31:0]          md_remainder,
    input  logic                 md_resultRDY,
    output logic [31:0]          chk_inA,
    output logic [15:0]          chk_inB,
    output logic [31:0]          chk_result,
    output logic [31:0]          chk_remainder,
    output logic                 chk_MULT,
    output logic                 chk_DIV,
    input  logic                 chk_outError,
    output logic                 busy,
    output logic [31:0]          data_result,
    output logic [31:0]          data_remainder,
    output logic                 data_resultRDY,
    output logic                 data_exception,
    output logic                 timeout,
    output logic                 fault_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clear_fault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      res_q;
    logic [31:0]      rem_q;

    assign busy           = (state != IDLE);
    assign chk_inA        = md_operandA;
    assign chk_inB        = md_operandB;
    assign chk_result     = res_q;
    assign chk_remainder  = rem_q;
    assign data_result    = res_q;
    assign data_remainder = rem_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            res_q          <= '0;
            rem_q          <= '0;
            md_start       <= 1'b0;
            md_MULT        <= 1'b0;
            md_DIV         <= 1'b0;
            md_operandA    <= '0;
            md_operandB    <= '0;
            chk_MULT       <= 1'b0;
            chk_DIV        <= 1'b0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            timeout        <= 1'b0;
            fault_sticky   <= 1'b0;
            err_count      <= '0;
        end else begin
            md_start       <= 1'b0;
            chk_MULT       <= 1'b0;
            chk_DIV        <= 1'b0;
            data_resultRDY <= 1'b0;

            case (state)
                IDLE: begin
                    if (ctrl_MULT ^ ctrl_DIV) begin
                        md_operandA    <= data_operandA;
                        md_operandB    <= data_operandB;
                        md_MULT        <= ctrl_MULT;
                        md_DIV         <= ctrl_DIV;
                        res_q          <= '0;
                        rem_q          <= '0;
                        timeout        <= 1'b0;
                        data_exception <= 1'b0;
                        md_start       <= 1'b1;
                        state          <= START;
                    end
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // A result arriving on the last allowed cycle beats the timeout
                    if (md_resultRDY) begin
                        res_q    <= md_result;
                        rem_q    <= md_remainder;
                        chk_MULT <= md_MULT;
                        chk_DIV  <= md_DIV;
                        state    <= CHECK;
                    end else if (wait_cnt == CNT_LAST) begin
                        res_q          <= '0;
                        rem_q          <= '0;
                        timeout        <= 1'b1;
                        data_exception <= 1'b1;
                        data_resultRDY <= 1'b1;
                        state          <= DONE;
                    end
                end
                CHECK: begin
                    data_exception <= chk_outError;
                    data_resultRDY <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Fault bookkeeping at the end of DONE; a same-cycle clear restarts the count at one
            if (state == DONE && data_exception) begin
                fault_sticky <= 1'b1;
                if (clear_fault)
                    err_count <= ERR_CNT_W'(1);
                else if (err_count != '1)
                    err_count <= err_count + ERR_CNT_W'(1);
            end else if (clear_fault) begin
                fault_sticky <= 1'b0;
                err_count    <= '0;
            end
        end
    end

endmodule
